// File: rtl/riscv_pkg.sv
// Shared fetch-side definitions: datapath width, reset PC, canonical NOP and
// the fetch FSM state encoding.
package riscv_pkg;

    localparam int              XLEN             = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] INSTR_NOP        = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer with flush; head entry is read straight from
// storage so it stays stable while the consumer stalls. DEPTH must be a power of 2.
module fetch_fifo #(
    parameter int  WIDTH = 64,
    parameter int  DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full;
    logic             push;
    logic             pop;

    assign empty_o   = (count_q == '0);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    // A write into a full buffer is only accepted when the same cycle frees the head slot.
    assign pop  = rd_en_i && !empty_o;
    assign push = wr_en_i && (!full || pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush_i) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues single-outstanding word reads and buffers replies for decode.
// Optional build macro FETCH_ILLEGAL_CHECK_EN adds a per-entry illegal-encoding flag.
module instr_fetch
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic            instr_illegal
);

`ifdef FETCH_ILLEGAL_CHECK_EN
    localparam int ENTRY_W = 2 * XLEN + 1;
`else
    localparam int ENTRY_W = 2 * XLEN;
`endif
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    fetch_state_e       state_q, state_d;
    logic [XLEN-1:0]    pc_q, pc_d;
    logic [XLEN-1:0]    req_pc_q;
    logic               req_fire;
    logic               rsp_take;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] head;

    // Only request when the reply is guaranteed a free slot.
    assign imem_req_valid = !reset && (state_q == S_REQ) && (fifo_count < CNT_W'(FIFO_DEPTH));
    assign imem_addr      = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_take       = imem_rsp_valid && (state_q == S_WAIT) && !redirect_valid;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (req_fire) pc_d = pc_q + 32'd4;
        case (state_q)
            S_REQ:          if (req_fire) state_d = S_WAIT;
            S_WAIT, S_DROP: if (imem_rsp_valid) state_d = S_REQ;
            default:        state_d = S_REQ;
        endcase
        // Redirect wins: any reply still owed to the old path must be swallowed.
        if (redirect_valid) begin
            pc_d = {redirect_pc[XLEN-1:2], 2'b00};
            if (state_q == S_REQ) state_d = req_fire ? S_DROP : S_REQ;
            else                  state_d = imem_rsp_valid ? S_REQ : S_DROP;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_REQ;
            pc_q    <= {RESET_PC[XLEN-1:2], 2'b00};
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire) req_pc_q <= pc_q;
    end

`ifdef FETCH_ILLEGAL_CHECK_EN
    assign wr_entry      = {(imem_rsp_data[1:0] != 2'b11), req_pc_q, imem_rsp_data};
    assign instr_illegal = !fifo_empty && head[2*XLEN];
`else
    assign wr_entry      = {req_pc_q, imem_rsp_data};
    assign instr_illegal = 1'b0;
`endif

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush_i   (redirect_valid),
        .wr_en_i   (rsp_take),
        .wr_data_i (wr_entry),
        .rd_en_i   (instr_ready),
        .rd_data_o (head),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    assign instr_valid = !fifo_empty;
    assign instr       = fifo_empty ? '0 : head[XLEN-1:0];
    assign instr_pc    = fifo_empty ? '0 : head[2*XLEN-1:XLEN];

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: memory responder model, program-order scoreboard,
// directed corner sequences, a vector table and a randomized run.
`timescale 1ns/1ps
module tb_instr_fetch;
    import riscv_pkg::*;

    localparam logic [31:0] RST_PC = RESET_PC_DEFAULT;
    localparam int          DEPTH  = 2;
`ifdef FETCH_ILLEGAL_CHECK_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, imem_req_valid, imem_req_ready, imem_rsp_valid;
    logic        redirect_valid, instr_valid, instr_ready, instr_illegal;
    logic [31:0] imem_addr, imem_rsp_data, redirect_pc, instr, instr_pc;

    instr_fetch #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .instr_pc(instr_pc), .instr_illegal(instr_illegal)
    );

    int checks = 0;
    int errors = 0;

    // memory model state
    bit          pending = 0;
    int          wait_cnt = 0;
    logic [31:0] pend_addr = '0;
    bit          rand_mem = 0;
    int          ready_pct = 100;
    int          fixed_lat = 1;
    bit          req_rdy_fixed = 1;
    bit          force_en = 0;
    logic [31:0] force_data = '0;
    // scoreboard state
    bit          sb_en = 0;
    logic [31:0] exp_pc = '0;
    int          consumed = 0;
    bit          hold_q = 0;
    logic [31:0] hold_addr = '0;

    typedef struct {
        logic [31:0] rpc;
        logic [31:0] data;
        logic [31:0] exp_pc;
        logic        exp_ill;
    } vec_t;
    vec_t vt[6];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic logic ill_model(input logic [31:0] w);
        return ILL_EN && (w[1:0] != 2'b11);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: capture pre-edge state, score it, advance memory model after the edge.
    task automatic step();
        bit acc, fire, cons, rdr, rst_s;
        logic [31:0] a, rp;
        #1;
        acc   = imem_req_valid && imem_req_ready;
        fire  = imem_rsp_valid;
        cons  = instr_valid && instr_ready;
        rdr   = redirect_valid;
        rp    = redirect_pc;
        rst_s = reset;
        a     = imem_addr;
        if (sb_en && !rst_s) begin
            if (cons) begin
                chk("sb_pc", instr_pc, exp_pc);
                chk("sb_instr", instr, mem_word(exp_pc));
                chk1("sb_illegal", instr_illegal, ill_model(mem_word(exp_pc)));
                exp_pc += 32'd4;
                consumed++;
            end
            if (rdr) exp_pc = {rp[31:2], 2'b00};
        end
        if (rst_s) exp_pc = RST_PC;
        if (acc && !rst_s) begin
            checks++;
            if (pending || a[1:0] != 2'b00) begin
                errors++;
                $display("FAIL req_proto: outstanding=%0b addr=%h, required outstanding=0 aligned", pending, a);
            end
        end
        if (hold_q && !rst_s) begin
            chk1("req_hold_valid", imem_req_valid, 1'b1);
            chk("req_hold_addr", a, hold_addr);
        end
        hold_q    = imem_req_valid && !imem_req_ready && !rdr && !rst_s;
        hold_addr = a;
        @(posedge clk);
        #1;
        if (rst_s) pending = 0;
        else begin
            if (fire) pending = 0;
            else if (pending && wait_cnt > 0) wait_cnt--;
            if (acc) begin
                pending   = 1;
                pend_addr = a;
                wait_cnt  = (rand_mem ? int'($urandom_range(3, 1)) : fixed_lat) - 1;
            end
        end
        imem_rsp_valid = pending && (wait_cnt == 0);
        imem_rsp_data  = force_en ? force_data : mem_word(pend_addr);
        imem_req_ready = rand_mem ? ($urandom_range(99, 0) < ready_pct) : req_rdy_fixed;
        redirect_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!instr_valid && n < 20) begin
            step();
            n++;
        end
        if (!instr_valid) begin
            checks++;
            errors++;
            $display("FAIL %s: instr_valid still 0 after %0d cycles, required 1", name, n);
        end
    endtask

    initial begin
        reset = 1'b1; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b1;

        vt[0] = '{32'h0000_0103, INSTR_NOP,    32'h0000_0100, 1'b0};
        vt[1] = '{32'h1000_0000, 32'h0000_0012, 32'h1000_0000, ILL_EN};
        vt[2] = '{32'hFFFF_FFFE, 32'hDEAD_BEEF, 32'hFFFF_FFFC, 1'b0};
        vt[3] = '{32'h8000_0005, 32'h0000_0001, 32'h8000_0004, ILL_EN};
        vt[4] = '{32'h0000_0040, 32'hFFFF_FFFF, 32'h0000_0040, 1'b0};
        vt[5] = '{32'h0000_0022, 32'h0000_0010, 32'h0000_0020, ILL_EN};

        // reset values, first-fetch latency, one instruction per two cycles
        sb_en = 1;
        step(); step();
        chk1("rst_req_valid", imem_req_valid, 1'b0);
        chk("rst_addr", imem_addr, RST_PC);
        chk1("rst_instr_valid", instr_valid, 1'b0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk1("rst_illegal", instr_illegal, 1'b0);
        reset = 1'b0;
        #1;
        chk1("c0_req_valid", imem_req_valid, 1'b1);
        chk("c0_addr", imem_addr, RST_PC);
        step(); chk1("c1_instr_valid", instr_valid, 1'b0);
        step(); chk1("c2_instr_valid", instr_valid, 1'b1); chk("c2_instr_pc", instr_pc, 32'h0);
        step(); chk1("c3_instr_valid", instr_valid, 1'b0);
        step(); chk1("c4_instr_valid", instr_valid, 1'b1); chk("c4_instr_pc", instr_pc, 32'h4);
        repeat (10) step();

        // decoder stall: buffer fills to depth, head held
        instr_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step();
            if (i >= 1) chk("stall_head_pc", instr_pc, 32'h0);
        end
        chk1("stall_valid", instr_valid, 1'b1);
        chk1("stall_req_valid", imem_req_valid, 1'b0);
        chk("stall_head_instr", instr, mem_word(32'h0));
        instr_ready = 1'b1;
        step();
        chk1("release_valid", instr_valid, 1'b1);
        chk("release_pc", instr_pc, 32'h4);
        repeat (10) step();

        // redirect in S_WAIT with reply in the same cycle
        do_reset();
        step();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        step();
        chk1("rdw_instr_valid", instr_valid, 1'b0);
        chk("rdw_addr", imem_addr, 32'h0000_0100);
        chk1("rdw_req_valid", imem_req_valid, 1'b1);
        wait_valid("rdw_wait");
        chk("rdw_pc", instr_pc, 32'h0000_0100);
        repeat (6) step();

        // request stalled by memory, then redirected
        req_rdy_fixed = 0;
        do_reset();
        step();
        for (int i = 0; i < 5; i++) begin
            chk1("nrdy_req_valid", imem_req_valid, 1'b1);
            chk("nrdy_addr", imem_addr, RST_PC);
            step();
        end
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
        step();
        chk("nrdy_rd_addr", imem_addr, 32'h0000_0200);
        chk1("nrdy_rd_req", imem_req_valid, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk1("nrdy_no_phantom", instr_valid, 1'b0);
        end
        req_rdy_fixed = 1;
        wait_valid("nrdy_wait");
        chk("nrdy_pc", instr_pc, 32'h0000_0200);
        repeat (4) step();

        // PC wrap at the top of the address space
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        for (int n = 0; n < 10 && !(imem_req_valid && imem_req_ready && imem_addr == 32'hFFFF_FFFC); n++) step();
        chk("wrap_req_addr", imem_addr, 32'hFFFF_FFFC);
        step();
        chk("wrap_next_addr", imem_addr, 32'h0000_0000);
        wait_valid("wrap_wait0");
        chk("wrap_pc0", instr_pc, 32'hFFFF_FFFC);
        step();
        wait_valid("wrap_wait1");
        chk("wrap_pc1", instr_pc, 32'h0000_0000);
        repeat (4) step();

        // vector table: redirect target alignment, returned word, illegal flag
        sb_en = 0;
        force_en = 1;
        for (int i = 0; i < 6; i++) begin
            force_data = vt[i].data;
            redirect_valid = 1'b1; redirect_pc = vt[i].rpc;
            step();
            chk1("vec_flush", instr_valid, 1'b0);
            wait_valid("vec_wait");
            chk("vec_pc", instr_pc, vt[i].exp_pc);
            chk("vec_instr", instr, vt[i].data);
            chk1("vec_illegal", instr_illegal, vt[i].exp_ill);
            step();
        end
        force_en = 0;

        // randomized traffic against the program-order scoreboard
        rand_mem = 1; ready_pct = 70; sb_en = 1;
        do_reset();
        consumed = 0;
        for (int c = 0; c < 4000; c++) begin
            instr_ready = ($urandom_range(9, 0) < 6);
            if ($urandom_range(99, 0) < 4) begin
                redirect_valid = 1'b1;
                redirect_pc    = $urandom;
            end
            reset = ($urandom_range(999, 0) == 0);
            step();
        end
        reset = 1'b0;
        checks++;
        if (consumed < 200) begin
            errors++;
            $display("FAIL rand_progress: consumed %0d instructions, required at least 200", consumed);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
